// File: rtl/dac_spi_tx.sv
// SPI transmitter for a dual-channel DAC: buffers one sin/cos pair and sends it
// as two 24-bit mode-0 frames (channel A = sin, channel B = cos).
module dac_spi_tx #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CS_GAP        = 2,
  parameter logic [7:0]  CMD_A         = 8'h30,
  parameter logic [7:0]  CMD_B         = 8'h31,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sin,
  input  logic [15:0] cos,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP_A,
    FRAME_B,
    GAP_B
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'd23;

  state_t      state_reg;
  logic [15:0] buf_data_reg [2];
  logic        buf_full_reg;
  logic [15:0] cos_latched_reg;
  logic [23:0] sreg_reg;
  logic [7:0]  div_cnt_reg;
  logic [7:0]  gap_cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic        sclk_reg;
  logic        cs_n_reg;
  logic        busy_reg;
  logic        overrun_reg;

  logic [15:0] conv_data [2];
  logic        consume;

  // Index 0 holds sin, index 1 holds cos.
  for (genvar gi = 0; gi < 2; gi++) begin : g_conv
    assign conv_data[gi] = OFFSET_BINARY ? {~buf_data_reg[gi][15], buf_data_reg[gi][14:0]}
                                         : buf_data_reg[gi];
  end

  assign consume = (state_reg == IDLE) && buf_full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      buf_data_reg[0] <= '0;
      buf_data_reg[1] <= '0;
      buf_full_reg    <= 1'b0;
      cos_latched_reg <= '0;
      sreg_reg        <= '0;
      div_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      bit_cnt_reg     <= '0;
      sclk_reg        <= 1'b0;
      cs_n_reg        <= 1'b1;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;

      // A strobe in the same cycle the buffer drains refills it without loss.
      if (sample_valid) begin
        if (!buf_full_reg || consume) begin
          buf_data_reg[0] <= sin;
          buf_data_reg[1] <= cos;
          buf_full_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (consume) begin
        buf_full_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (buf_full_reg) begin
            sreg_reg        <= {CMD_A, conv_data[0]};
            cos_latched_reg <= conv_data[1];
            cs_n_reg        <= 1'b0;
            busy_reg        <= 1'b1;
            sclk_reg        <= 1'b0;
            div_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            state_reg       <= FRAME_A;
          end
        end

        FRAME_A, FRAME_B: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= ~sclk_reg;
            // Falling edge: advance the data so it settles while sclk is low.
            if (sclk_reg) begin
              sreg_reg <= {sreg_reg[22:0], 1'b0};
              if (bit_cnt_reg == BIT_LAST) begin
                cs_n_reg    <= 1'b1;
                gap_cnt_reg <= '0;
                bit_cnt_reg <= '0;
                state_reg   <= (state_reg == FRAME_A) ? GAP_A : GAP_B;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end

        GAP_A: begin
          if (gap_cnt_reg == GAP_LAST) begin
            sreg_reg    <= {CMD_B, cos_latched_reg};
            cs_n_reg    <= 1'b0;
            sclk_reg    <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= FRAME_B;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end

        GAP_B: begin
          if (gap_cnt_reg == GAP_LAST) begin
            busy_reg    <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sclk    = sclk_reg;
  assign mosi    = sreg_reg[23];
  assign cs_n    = cs_n_reg;
  assign busy    = busy_reg;
  assign overrun = overrun_reg;

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Downstream stage of the sine/cosine generator. Captures each new sin/cos sample pair on a one-cycle strobe and serialises it to a dual-channel SPI DAC as two 24-bit frames: channel A carries sin, channel B carries cos. A one-deep holding buffer decouples the sample strobe from the serial transfer. Any sample that arrives while the buffer is still full is dropped and flagged.

## Interface
- CLK_DIV, default 2: clk cycles per SCLK half-period, legal range 1..255.
- CS_GAP, default 2: clk cycles cs_n stays high between frames, legal range 1..255.
- CMD_A, default 8'h30: command/address byte for the channel A (sin) frame.
- CMD_B, default 8'h31: command/address byte for the channel B (cos) frame.
- OFFSET_BINARY, default 1: when 1, invert the data MSB (two's complement to offset binary). When 0, send data unchanged.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- sample_valid  in  1  one-cycle strobe: sin/cos are valid this cycle.
- sin  in  16  signed sample for channel A.
- cos  in  16  signed sample for channel B.
- sclk  out  1  SPI clock, CPOL=0.
- mosi  out  1  SPI data, MSB first.
- cs_n  out  1  SPI chip select, active low.
- busy  out  1  high while a frame or inter-frame gap is in progress.
- overrun  out  1  one-cycle pulse when a sample is dropped.

## Operation
- Buffer behaviour:
  - sample_valid with the buffer empty: store {sin, cos} and set buf_full.
  - sample_valid with the buffer full: discard the new sample, keep the old one, and pulse overrun.
  - The buffer empties in the cycle its contents move into the shift logic. A sample_valid in that same cycle is accepted, with no overrun.
- Data conversion: data = OFFSET_BINARY ? {x[15]^1, x[14:0]} : x.
- Frame layout: 24 bits = {CMD, data[15:0]}, sent bit 23 first.
- State machine IDLE -> FRAME_A -> GAP_A -> FRAME_B -> GAP_B:
  - IDLE: if buf_full, load the shift register with {CMD_A, conv(sin)}, latch conv(cos), free the buffer, go to FRAME_A.
  - FRAME_A / FRAME_B:
    - cs_n=0 and mosi = current bit.
    - A half-period counter counts CLK_DIV cycles. On expiry, sclk toggles.
    - On a falling edge, shift to the next bit.
    - After the 24th falling edge, go to the following GAP state.
  - GAP_A: cs_n=1 for CS_GAP cycles, then load {CMD_B, cos_latched} and go to FRAME_B.
  - GAP_B: cs_n=1 for CS_GAP cycles, then go to IDLE.
  - An IDLE state that finds buf_full set starts the next pair immediately.
- SPI mode 0: mosi changes only while sclk is low. The DAC samples mosi on sclk rising edges.
- The bit counter counts 0..23. Exactly 24 rising sclk edges occur per frame.

## Timing
- Reset values (asynchronous, applied immediately on rst_n low): cs_n=1, sclk=0, mosi=0, busy=0, overrun=0, buf_full=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame. The DAC sees cs_n rise with fewer than 24 clocks and discards the partial word. Nothing resumes after reset.
- Latency from sample_valid (edge N, state IDLE, buffer empty):
  - buf_full=1 after edge N.
  - cs_n=0, busy=1 and mosi=bit23 after edge N+1.
  - First sclk rise after edge N+1+CLK_DIV.
- Frame length: 48·CLK_DIV cycles with cs_n low.
- Full pair: 2·(48·CLK_DIV + CS_GAP) cycles from cs_n falling to return to IDLE.
  - With defaults this is 196 cycles, well inside the 1250 cycles per sample at 10 MHz / 8 kHz.
- busy is high from the first FRAME_A cycle to the last GAP_B cycle inclusive.
- overrun is registered: it is high for exactly the one cycle after the offending edge.
- sclk and mosi come straight from flops, with no combinational paths to outputs.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 with sample_valid toggling.
  - Response: cs_n=1, sclk=0, mosi=0, busy=0, overrun=0 throughout.
  - After release: no SPI activity until the first sample_valid.
- Single sample:
  - Stimulus: sin=16'h7FFF, cos=16'h8000, OFFSET_BINARY=1, CLK_DIV=2, CS_GAP=2.
  - Response: cs_n low one cycle after the strobe. Frame A is 24'h30FFFF and frame B is 24'h310000, each with exactly 24 sclk rises. cs_n is high 2 cycles between frames. busy is high for 196 cycles.
- Back-to-back:
  - Stimulus: a second strobe (sin=16'h0001, cos=16'hFFFF) during frame A of the first pair.
  - Response: no overrun. The second pair starts 1 cycle after GAP_B ends, with frames 24'h308001 and 24'h317FFF.
- Overrun:
  - Stimulus: a third strobe while the buffer still holds the second pair.
  - Response: overrun is high for exactly 1 cycle. The third sample never appears on mosi, and the second pair is sent intact.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 after the 10th sclk rise of frame A.
  - Response: cs_n=1 and sclk=0 immediately. After release the block stays idle and the buffer is empty.
- Edge timing:
  - Stimulus: CLK_DIV=1, OFFSET_BINARY=0, sin=16'hA5A5.
  - Response: sclk toggles every clk cycle. mosi is stable across every sclk rise. Frame A is 24'h30A5A5 with a total cs_n-low time of 48 cycles.
